// File: rtl/alu_split_operand.sv
// alu_split_operand
//   Registered ALU whose operands A and B may arrive in different cycles.
//   A command is accepted in IDLE. Any operand it still needs is waited for in
//   WAIT, up to TIMEOUT cycles. The result is produced from EXEC after one
//   cycle, or from MUL after MUL_LAT cycles for multiply commands.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   ce_i           clock enable; 0 freezes all state and outputs, masks res_valid_o
//   mode_i         1 = arithmetic, 0 = logic
//   cmd_i          operation code
//   inp_valid_i    bit0 = opa_i valid, bit1 = opb_i valid
//   opa_i, opb_i   operands
//   cin_i          carry in
//   res_o          result, zero-extended except for multiply
//   cout_o         carry out (ADD, ADD_CIN, INC_A, INC_B)
//   oflow_o        borrow (SUB, SUB_CIN, DEC_A, DEC_B)
//   g_o, e_o, l_o  A>B, A==B, A<B (CMP only)
//   err_o          illegal command, rotate amount out of range, or operand timeout
//   res_valid_o    one-cycle strobe; the result outputs were updated this cycle
//   busy_o         high in EXEC and MUL; inputs are ignored while high
//   state_o        current FSM state (0 IDLE, 1 WAIT, 2 EXEC, 3 MUL)
//
// Handshake: an operand is taken when its inp_valid_i bit is high at a rising
// clock edge with ce_i=1 and busy_o=0. Each accepted command produces exactly
// one res_valid_o pulse, unless reset aborts it. The result outputs hold their
// values until the next pulse. A new command may be presented in the cycle
// that res_valid_o is high.
module alu_split_operand #(
    parameter int WIDTH   = 8,
    parameter int CWIDTH  = 4,
    parameter int TIMEOUT = 16,
    parameter int MUL_LAT = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ce_i,
    input  logic                 mode_i,
    input  logic [CWIDTH-1:0]    cmd_i,
    input  logic [1:0]           inp_valid_i,
    input  logic [WIDTH-1:0]     opa_i,
    input  logic [WIDTH-1:0]     opb_i,
    input  logic                 cin_i,
    output logic [2*WIDTH-1:0]   res_o,
    output logic                 cout_o,
    output logic                 oflow_o,
    output logic                 g_o,
    output logic                 e_o,
    output logic                 l_o,
    output logic                 err_o,
    output logic                 res_valid_o,
    output logic                 busy_o,
    output logic [1:0]           state_o
);

    localparam int SW   = $clog2(WIDTH);
    localparam int CMAX = (TIMEOUT > MUL_LAT) ? TIMEOUT : MUL_LAT;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // Arithmetic command codes (mode 1)
    localparam logic [CWIDTH-1:0] A_ADD     = CWIDTH'(0);
    localparam logic [CWIDTH-1:0] A_SUB     = CWIDTH'(1);
    localparam logic [CWIDTH-1:0] A_ADD_CIN = CWIDTH'(2);
    localparam logic [CWIDTH-1:0] A_SUB_CIN = CWIDTH'(3);
    localparam logic [CWIDTH-1:0] A_INC_A   = CWIDTH'(4);
    localparam logic [CWIDTH-1:0] A_DEC_A   = CWIDTH'(5);
    localparam logic [CWIDTH-1:0] A_INC_B   = CWIDTH'(6);
    localparam logic [CWIDTH-1:0] A_DEC_B   = CWIDTH'(7);
    localparam logic [CWIDTH-1:0] A_CMP     = CWIDTH'(8);
    localparam logic [CWIDTH-1:0] A_MUL_INC = CWIDTH'(9);
    localparam logic [CWIDTH-1:0] A_MUL_SHL = CWIDTH'(10);
    // Logic command codes (mode 0)
    localparam logic [CWIDTH-1:0] L_AND     = CWIDTH'(0);
    localparam logic [CWIDTH-1:0] L_NAND    = CWIDTH'(1);
    localparam logic [CWIDTH-1:0] L_OR      = CWIDTH'(2);
    localparam logic [CWIDTH-1:0] L_NOR     = CWIDTH'(3);
    localparam logic [CWIDTH-1:0] L_XOR     = CWIDTH'(4);
    localparam logic [CWIDTH-1:0] L_XNOR    = CWIDTH'(5);
    localparam logic [CWIDTH-1:0] L_NOT_A   = CWIDTH'(6);
    localparam logic [CWIDTH-1:0] L_NOT_B   = CWIDTH'(7);
    localparam logic [CWIDTH-1:0] L_SHR1_A  = CWIDTH'(8);
    localparam logic [CWIDTH-1:0] L_SHL1_A  = CWIDTH'(9);
    localparam logic [CWIDTH-1:0] L_SHR1_B  = CWIDTH'(10);
    localparam logic [CWIDTH-1:0] L_SHL1_B  = CWIDTH'(11);
    localparam logic [CWIDTH-1:0] L_ROL     = CWIDTH'(12);
    localparam logic [CWIDTH-1:0] L_ROR     = CWIDTH'(13);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_EXEC = 2'd2,
        S_MUL  = 2'd3
    } state_t;

    // Commands that use B only do not need A. Illegal codes need both operands.
    function automatic logic need_a_f(input logic m, input logic [CWIDTH-1:0] c);
        if (m) need_a_f = !(c == A_INC_B || c == A_DEC_B);
        else   need_a_f = !(c == L_NOT_B || c == L_SHR1_B || c == L_SHL1_B);
    endfunction

    // Commands that use A only do not need B.
    function automatic logic need_b_f(input logic m, input logic [CWIDTH-1:0] c);
        if (m) need_b_f = !(c == A_INC_A || c == A_DEC_A);
        else   need_b_f = !(c == L_NOT_A || c == L_SHR1_A || c == L_SHL1_A);
    endfunction

    function automatic logic is_mul_f(input logic m, input logic [CWIDTH-1:0] c);
        is_mul_f = m && (c == A_MUL_INC || c == A_MUL_SHL);
    endfunction

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [CWIDTH-1:0]    cmd_q;
    logic                 mode_q;
    logic                 cin_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic                 have_a_q;
    logic                 have_b_q;
    logic [2*WIDTH-1:0]   res_q;
    logic                 cout_q;
    logic                 oflow_q;
    logic                 g_q;
    logic                 e_q;
    logic                 l_q;
    logic                 err_q;
    logic                 res_valid_q;
    logic                 busy_q;

    // Next-value results computed from the held command and operands
    logic [2*WIDTH-1:0]   res_d;
    logic                 cout_d;
    logic                 oflow_d;
    logic                 g_d;
    logic                 e_d;
    logic                 l_d;
    logic                 err_d;

    logic [WIDTH:0]       a_ext;
    logic [WIDTH:0]       b_ext;
    logic [WIDTH:0]       cin_ext;
    logic [WIDTH:0]       one_ext;
    logic [WIDTH:0]       t_w1;
    logic [WIDTH-1:0]     t_w;
    logic [2*WIDTH-1:0]   m_a;
    logic [2*WIDTH-1:0]   m_b;
    logic [2*WIDTH-1:0]   rot_dbl;
    logic [SW-1:0]        rot_amt;
    logic                 rot_hi;

    logic                 idle_complete;
    logic                 idle_mul;
    logic                 held_need_a;
    logic                 held_need_b;
    logic                 wait_complete;
    logic                 take_a;
    logic                 take_b;

    assign a_ext   = {1'b0, a_q};
    assign b_ext   = {1'b0, b_q};
    assign cin_ext = {{WIDTH{1'b0}}, cin_q};
    assign one_ext = {{WIDTH{1'b0}}, 1'b1};
    assign rot_amt = b_q[SW-1:0];
    // Any B bit above the rotate-amount field makes the rotate illegal
    assign rot_hi  = |b_q[WIDTH-1:SW];

    assign idle_complete = (inp_valid_i[0] || !need_a_f(mode_i, cmd_i)) &&
                           (inp_valid_i[1] || !need_b_f(mode_i, cmd_i));
    assign idle_mul      = is_mul_f(mode_i, cmd_i);

    // In WAIT only the missing operand is sampled; a held operand is never overwritten
    assign held_need_a   = need_a_f(mode_q, cmd_q);
    assign held_need_b   = need_b_f(mode_q, cmd_q);
    assign take_a        = held_need_a && !have_a_q && inp_valid_i[0];
    assign take_b        = held_need_b && !have_b_q && inp_valid_i[1];
    assign wait_complete = (!held_need_a || have_a_q || inp_valid_i[0]) &&
                           (!held_need_b || have_b_q || inp_valid_i[1]);

    always_comb begin
        res_d   = '0;
        cout_d  = 1'b0;
        oflow_d = 1'b0;
        g_d     = 1'b0;
        e_d     = 1'b0;
        l_d     = 1'b0;
        err_d   = 1'b0;
        t_w1    = '0;
        t_w     = '0;
        m_a     = '0;
        m_b     = '0;
        rot_dbl = '0;
        if (mode_q) begin
            case (cmd_q)
                A_ADD:     begin t_w1 = a_ext + b_ext;           cout_d  = t_w1[WIDTH]; end
                A_ADD_CIN: begin t_w1 = a_ext + b_ext + cin_ext; cout_d  = t_w1[WIDTH]; end
                A_INC_A:   begin t_w1 = a_ext + one_ext;         cout_d  = t_w1[WIDTH]; end
                A_INC_B:   begin t_w1 = b_ext + one_ext;         cout_d  = t_w1[WIDTH]; end
                // Bit WIDTH of a (WIDTH+1)-bit difference is the borrow
                A_SUB:     begin t_w1 = a_ext - b_ext;           oflow_d = t_w1[WIDTH]; end
                A_SUB_CIN: begin t_w1 = a_ext - b_ext - cin_ext; oflow_d = t_w1[WIDTH]; end
                A_DEC_A:   begin t_w1 = a_ext - one_ext;         oflow_d = t_w1[WIDTH]; end
                A_DEC_B:   begin t_w1 = b_ext - one_ext;         oflow_d = t_w1[WIDTH]; end
                A_CMP: begin
                    g_d = (a_q > b_q);
                    e_d = (a_q == b_q);
                    l_d = (a_q < b_q);
                end
                A_MUL_INC: begin
                    m_a = {{(WIDTH-1){1'b0}}, a_ext + one_ext};
                    m_b = {{(WIDTH-1){1'b0}}, b_ext + one_ext};
                end
                A_MUL_SHL: begin
                    m_a = {{WIDTH{1'b0}}, a_q[WIDTH-2:0], 1'b0};
                    m_b = {{WIDTH{1'b0}}, b_q};
                end
                default: err_d = 1'b1;
            endcase
            if (is_mul_f(mode_q, cmd_q)) begin
                res_d = m_a * m_b;
            end else if (cmd_q == A_ADD || cmd_q == A_ADD_CIN ||
                         cmd_q == A_INC_A || cmd_q == A_INC_B) begin
                res_d = {{(WIDTH-1){1'b0}}, t_w1};
            end else if (cmd_q == A_SUB || cmd_q == A_SUB_CIN ||
                         cmd_q == A_DEC_A || cmd_q == A_DEC_B) begin
                res_d = {{WIDTH{1'b0}}, t_w1[WIDTH-1:0]};
            end
        end else begin
            case (cmd_q)
                L_AND:    t_w = a_q & b_q;
                L_NAND:   t_w = ~(a_q & b_q);
                L_OR:     t_w = a_q | b_q;
                L_NOR:    t_w = ~(a_q | b_q);
                L_XOR:    t_w = a_q ^ b_q;
                L_XNOR:   t_w = ~(a_q ^ b_q);
                L_NOT_A:  t_w = ~a_q;
                L_NOT_B:  t_w = ~b_q;
                L_SHR1_A: t_w = a_q >> 1;
                L_SHL1_A: t_w = a_q << 1;
                L_SHR1_B: t_w = b_q >> 1;
                L_SHL1_B: t_w = b_q << 1;
                // Rotates shift a doubled copy of A and keep one window of it
                L_ROL: begin
                    if (rot_hi) begin
                        err_d = 1'b1;
                    end else begin
                        rot_dbl = {a_q, a_q} << rot_amt;
                        t_w     = rot_dbl[2*WIDTH-1:WIDTH];
                    end
                end
                L_ROR: begin
                    if (rot_hi) begin
                        err_d = 1'b1;
                    end else begin
                        rot_dbl = {a_q, a_q} >> rot_amt;
                        t_w     = rot_dbl[WIDTH-1:0];
                    end
                end
                default: err_d = 1'b1;
            endcase
            res_d = {{WIDTH{1'b0}}, t_w};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cmd_q       <= '0;
            mode_q      <= 1'b0;
            cin_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            have_a_q    <= 1'b0;
            have_b_q    <= 1'b0;
            res_q       <= '0;
            cout_q      <= 1'b0;
            oflow_q     <= 1'b0;
            g_q         <= 1'b0;
            e_q         <= 1'b0;
            l_q         <= 1'b0;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (ce_i) begin
            res_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (inp_valid_i != 2'b00) begin
                        cmd_q    <= cmd_i;
                        mode_q   <= mode_i;
                        cin_q    <= cin_i;
                        have_a_q <= inp_valid_i[0];
                        have_b_q <= inp_valid_i[1];
                        cnt_q    <= '0;
                        if (inp_valid_i[0]) a_q <= opa_i;
                        if (inp_valid_i[1]) b_q <= opb_i;
                        if (idle_complete) begin
                            state_q <= idle_mul ? S_MUL : S_EXEC;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_complete) begin
                        if (take_a) begin
                            a_q      <= opa_i;
                            have_a_q <= 1'b1;
                        end
                        if (take_b) begin
                            b_q      <= opb_i;
                            have_b_q <= 1'b1;
                        end
                        cnt_q   <= '0;
                        state_q <= is_mul_f(mode_q, cmd_q) ? S_MUL : S_EXEC;
                        busy_q  <= 1'b1;
                    end else if (cnt_q == TO_LAST) begin
                        // Operand never arrived: report an error result
                        res_q       <= '0;
                        cout_q      <= 1'b0;
                        oflow_q     <= 1'b0;
                        g_q         <= 1'b0;
                        e_q         <= 1'b0;
                        l_q         <= 1'b0;
                        err_q       <= 1'b1;
                        res_valid_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_EXEC, S_MUL: begin
                    if (state_q == S_EXEC || cnt_q == MUL_LAST) begin
                        res_q       <= res_d;
                        cout_q      <= cout_d;
                        oflow_q     <= oflow_d;
                        g_q         <= g_d;
                        e_q         <= e_d;
                        l_q         <= l_d;
                        err_q       <= err_d;
                        res_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign res_o       = res_q;
    assign cout_o      = cout_q;
    assign oflow_o     = oflow_q;
    assign g_o         = g_q;
    assign e_o         = e_q;
    assign l_o         = l_q;
    assign err_o       = err_q;
    // A strobe that lands while the clock is disabled shows once ce_i returns
    assign res_valid_o = res_valid_q & ce_i;
    assign busy_o      = busy_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_alu_split_operand.sv
// Testbench for alu_split_operand (WIDTH=8, TIMEOUT=16, MUL_LAT=3).
// A table of single-shot vectors is followed by hand-written sequences for
// split operands, timeout, clock-enable stall, multiply busy and reset abort.
module tb_alu_split_operand;

    localparam int WIDTH = 8;
    localparam int EW    = 2*WIDTH + 6;

    // Flag vectors packed as {cout, oflow, g, e, l, err}
    localparam logic [5:0] F_0   = 6'b000000;
    localparam logic [5:0] F_C   = 6'b100000;
    localparam logic [5:0] F_O   = 6'b010000;
    localparam logic [5:0] F_G   = 6'b001000;
    localparam logic [5:0] F_E   = 6'b000100;
    localparam logic [5:0] F_L   = 6'b000010;
    localparam logic [5:0] F_ERR = 6'b000001;

    typedef struct {
        logic        mode;
        logic [3:0]  cmd;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        cin;
        logic [15:0] res;
        logic [5:0]  fl;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         ce;
    logic         mode;
    logic [3:0]   cmd;
    logic [1:0]   inp_valid;
    logic [7:0]   opa;
    logic [7:0]   opb;
    logic         cin;
    logic [15:0]  res;
    logic         cout;
    logic         oflow;
    logic         g;
    logic         e;
    logic         l;
    logic         err;
    logic         res_valid;
    logic         busy;
    logic [1:0]   state;

    int checks   = 0;
    int failures = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_act;
    logic [EW-1:0] mon_exp;
    vec_t vecs[$];

    alu_split_operand #(
        .WIDTH(WIDTH), .CWIDTH(4), .TIMEOUT(16), .MUL_LAT(3)
    ) dut (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .mode_i(mode), .cmd_i(cmd),
        .inp_valid_i(inp_valid), .opa_i(opa), .opb_i(opb), .cin_i(cin),
        .res_o(res), .cout_o(cout), .oflow_o(oflow), .g_o(g), .e_o(e), .l_o(l),
        .err_o(err), .res_valid_o(res_valid), .busy_o(busy), .state_o(state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && res_valid) begin
            checks++;
            mon_act = {res, cout, oflow, g, e, l, err};
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_result: got res=0x%h flags=%b, no result expected",
                         res, mon_act[5:0]);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    failures++;
                    $display("FAIL result: got res=0x%h flags=%b, expected res=0x%h flags=%b",
                             mon_act[EW-1:6], mon_act[5:0], mon_exp[EW-1:6], mon_exp[5:0]);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic vec_t mkv(input logic m, input logic [3:0] c, input logic [7:0] a,
                                 input logic [7:0] b, input logic ci,
                                 input logic [15:0] r, input logic [5:0] f);
        vec_t v;
        v.mode = m; v.cmd = c; v.a = a; v.b = b; v.cin = ci; v.res = r; v.fl = f;
        return v;
    endfunction

    // Present one command for a single cycle; returns just after the accept edge
    task automatic send(input logic m, input logic [3:0] c, input logic [1:0] v,
                        input logic [7:0] a, input logic [7:0] b, input logic ci);
        @(posedge clk); #1;
        mode = m; cmd = c; inp_valid = v; opa = a; opb = b; cin = ci;
        @(posedge clk); #1;
        inp_valid = 2'b00;
    endtask

    // Number of edges after the accept edge until res_valid is seen
    task automatic wait_rv(input int budget, output int lat);
        lat = 0;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk); #1;
            if (res_valid) begin
                lat = n;
                break;
            end
        end
        if (lat == 0) begin
            checks++;
            failures++;
            $display("FAIL rv_wait: no res_valid within %0d cycles", budget);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int lat_exp;
        logic seen;
        vec_t v;

        ce = 1'b1; mode = 1'b0; cmd = '0; inp_valid = 2'b00; opa = '0; opb = '0; cin = 1'b0;

        // Arithmetic vectors
        vecs.push_back(mkv(1,  0, 8'hFF, 8'h01, 0, 16'h0100, F_C));
        vecs.push_back(mkv(1,  0, 8'h12, 8'h34, 0, 16'h0046, F_0));
        vecs.push_back(mkv(1,  1, 8'h50, 8'h20, 0, 16'h0030, F_0));
        vecs.push_back(mkv(1,  1, 8'h10, 8'h20, 0, 16'h00F0, F_O));
        vecs.push_back(mkv(1,  2, 8'hFF, 8'h00, 1, 16'h0100, F_C));
        vecs.push_back(mkv(1,  3, 8'h05, 8'h05, 1, 16'h00FF, F_O));
        vecs.push_back(mkv(1,  3, 8'h07, 8'h05, 1, 16'h0001, F_0));
        vecs.push_back(mkv(1,  4, 8'hFF, 8'h55, 0, 16'h0100, F_C));
        vecs.push_back(mkv(1,  5, 8'h00, 8'h55, 0, 16'h00FF, F_O));
        vecs.push_back(mkv(1,  6, 8'h33, 8'h7F, 0, 16'h0080, F_0));
        vecs.push_back(mkv(1,  7, 8'h33, 8'h01, 0, 16'h0000, F_0));
        vecs.push_back(mkv(1,  8, 8'h05, 8'h09, 0, 16'h0000, F_L));
        vecs.push_back(mkv(1,  8, 8'h09, 8'h09, 0, 16'h0000, F_E));
        vecs.push_back(mkv(1,  8, 8'hA0, 8'h09, 0, 16'h0000, F_G));
        vecs.push_back(mkv(1,  9, 8'h03, 8'h04, 0, 16'h0014, F_0));
        vecs.push_back(mkv(1,  9, 8'hFF, 8'hFF, 0, 16'h0000, F_0));
        vecs.push_back(mkv(1, 10, 8'h81, 8'h03, 0, 16'h0006, F_0));
        vecs.push_back(mkv(1, 10, 8'h7F, 8'hFF, 0, 16'hFD02, F_0));
        vecs.push_back(mkv(1, 15, 8'h12, 8'h34, 0, 16'h0000, F_ERR));
        vecs.push_back(mkv(1, 11, 8'h12, 8'h34, 0, 16'h0000, F_ERR));
        // Logic vectors, A=0xC5 B=0x3C unless a rotate
        vecs.push_back(mkv(0,  0, 8'hC5, 8'h3C, 0, 16'h0004, F_0));
        vecs.push_back(mkv(0,  1, 8'hC5, 8'h3C, 0, 16'h00FB, F_0));
        vecs.push_back(mkv(0,  2, 8'hC5, 8'h3C, 0, 16'h00FD, F_0));
        vecs.push_back(mkv(0,  3, 8'hC5, 8'h3C, 0, 16'h0002, F_0));
        vecs.push_back(mkv(0,  4, 8'hC5, 8'h3C, 0, 16'h00F9, F_0));
        vecs.push_back(mkv(0,  5, 8'hC5, 8'h3C, 0, 16'h0006, F_0));
        vecs.push_back(mkv(0,  6, 8'hC5, 8'h3C, 0, 16'h003A, F_0));
        vecs.push_back(mkv(0,  7, 8'hC5, 8'h3C, 0, 16'h00C3, F_0));
        vecs.push_back(mkv(0,  8, 8'hC5, 8'h3C, 0, 16'h0062, F_0));
        vecs.push_back(mkv(0,  9, 8'hC5, 8'h3C, 0, 16'h008A, F_0));
        vecs.push_back(mkv(0, 10, 8'hC5, 8'h3C, 0, 16'h001E, F_0));
        vecs.push_back(mkv(0, 11, 8'hC5, 8'h3C, 0, 16'h0078, F_0));
        vecs.push_back(mkv(0, 12, 8'h81, 8'h01, 0, 16'h0003, F_0));
        vecs.push_back(mkv(0, 13, 8'h81, 8'h01, 0, 16'h00C0, F_0));
        vecs.push_back(mkv(0, 12, 8'h81, 8'h10, 0, 16'h0000, F_ERR));
        vecs.push_back(mkv(0, 12, 8'hC5, 8'h03, 0, 16'h002E, F_0));
        vecs.push_back(mkv(0, 13, 8'hC5, 8'h07, 0, 16'h008B, F_0));
        vecs.push_back(mkv(0, 13, 8'h81, 8'h80, 0, 16'h0000, F_ERR));
        vecs.push_back(mkv(0, 14, 8'h12, 8'h34, 0, 16'h0000, F_ERR));

        // ---- reset ----
        #1 rst = 1'b1;
        #12;
        chk("reset_outputs", {res, cout, oflow, g, e, l, err, res_valid, busy}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_state", {30'h0, state}, 32'h0);
        chk("idle_busy", {31'h0, busy}, 32'h0);

        // ---- table vectors, both operands valid ----
        foreach (vecs[i]) begin
            v = vecs[i];
            exp_q.push_back({v.res, v.fl});
            send(v.mode, v.cmd, 2'b11, v.a, v.b, v.cin);
            lat_exp = (v.mode && (v.cmd == 4'd9 || v.cmd == 4'd10)) ? 3 : 1;
            wait_rv(8, lat);
            chk($sformatf("vec%0d_latency", i), lat, lat_exp);
            chk($sformatf("vec%0d_busy", i), {31'h0, busy}, 32'h0);
        end

        // ---- split operands: A, five idle cycles, then B with a junk A ----
        exp_q.push_back({16'h00F0, F_O});
        @(posedge clk); #1;
        mode = 1'b1; cmd = 4'd1; inp_valid = 2'b01; opa = 8'h10; opb = 8'h99; cin = 1'b0;
        @(posedge clk); #1;
        chk("split_wait_state", {30'h0, state}, 32'h1);
        chk("split_wait_busy", {31'h0, busy}, 32'h0);
        inp_valid = 2'b00; cmd = 4'd0; mode = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("split_still_wait", {30'h0, state}, 32'h1);
        inp_valid = 2'b11; opa = 8'hEE; opb = 8'h20;
        @(posedge clk); #1;
        inp_valid = 2'b00;
        wait_rv(8, lat);
        chk("split_latency", lat, 1);

        // ---- timeout ----
        exp_q.push_back({16'h0000, F_ERR});
        send(1, 0, 2'b01, 8'h42, 8'h00, 0);
        wait_rv(30, lat);
        chk("timeout_latency", lat, 16);
        @(posedge clk); #1;
        chk("timeout_idle", {30'h0, state}, 32'h0);

        // ---- timeout with a 4-cycle clock-enable stall ----
        exp_q.push_back({16'h0000, F_ERR});
        send(1, 0, 2'b01, 8'h42, 8'h00, 0);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (n == 3) ce = 1'b0;
            if (n == 5) chk("stall_state", {30'h0, state}, 32'h1);
            if (n == 7) ce = 1'b1;
            if (res_valid) begin
                lat = n;
                break;
            end
        end
        chk("stall_timeout_latency", lat, 20);

        // ---- multiply with a competing command held while busy ----
        exp_q.push_back({16'h0014, F_0});
        @(posedge clk); #1;
        mode = 1'b1; cmd = 4'd9; opa = 8'h03; opb = 8'h04; cin = 1'b0; inp_valid = 2'b11;
        @(posedge clk); #1;
        chk("mul_busy_accept", {31'h0, busy}, 32'h1);
        cmd = 4'd0; opa = 8'h01; opb = 8'h01;
        for (int n = 1; n <= 3; n++) begin
            @(posedge clk); #1;
            if (n < 3) begin
                chk("mul_busy", {31'h0, busy}, 32'h1);
                chk("mul_no_rv", {31'h0, res_valid}, 32'h0);
            end else begin
                chk("mul_rv", {31'h0, res_valid}, 32'h1);
                chk("mul_busy_done", {31'h0, busy}, 32'h0);
            end
        end
        inp_valid = 2'b00;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (res_valid) seen = 1'b1;
        end
        chk("mul_junk_ignored", {31'h0, seen}, 32'h0);

        // ---- reset in the middle of a multiply ----
        @(posedge clk); #1;
        mode = 1'b1; cmd = 4'd9; opa = 8'h03; opb = 8'h04; inp_valid = 2'b11;
        @(posedge clk); #1;
        inp_valid = 2'b00;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("rst_mid_mul_outputs", {res, cout, oflow, g, e, l, err, res_valid, busy}, 32'h0);
        chk("rst_mid_mul_state", {30'h0, state}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (res_valid) seen = 1'b1;
        end
        chk("rst_no_rv", {31'h0, seen}, 32'h0);

        // ---- normal operation after reset ----
        exp_q.push_back({16'h0046, F_0});
        send(1, 0, 2'b11, 8'h12, 8'h34, 0);
        wait_rv(8, lat);
        chk("after_rst_latency", lat, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_split_operand.md
Name: alu_split_operand

Overview:
Parametrised, registered ALU and the next generation of the team's 16-cycle operand-wait ALU. Width, operand-wait timeout and multiplier latency are all parameters. Operands A and B may arrive in different cycles. New over the previous generation:
- explicit RES_VALID result strobe;
- BUSY back-pressure output;
- error on illegal command or operand timeout.

It sits between the bench interface and the scoreboard, as the DUT for the alu test suite.

Parameters:
WIDTH, 8, operand width in bits
CWIDTH, 4, command field width
TIMEOUT, 16, cycles to wait for the missing operand before flagging ERR (≥1)
MUL_LAT, 3, cycles from operand-complete to RES_VALID for multiply commands (≥2)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
CE  in  1  clock enable; 0 freezes all state and outputs
MODE  in  1  1 = arithmetic, 0 = logic
CMD  in  CWIDTH  operation code
INP_VALID  in  2  00 none, 01 OPA valid, 10 OPB valid, 11 both valid
OPA  in  WIDTH  operand A
OPB  in  WIDTH  operand B
CIN  in  1  carry in
RES  out  2*WIDTH  result, zero-extended except for multiply
COUT  out  1  carry out (ADD, ADD_CIN, INC)
OFLOW  out  1  borrow/underflow (SUB, SUB_CIN, DEC)
G  out  1  A>B (CMP only)
E  out  1  A==B (CMP only)
L  out  1  A<B (CMP only)
ERR  out  1  illegal command, rotate-amount error, or timeout
RES_VALID  out  1  one-cycle pulse; result outputs updated this cycle
BUSY  out  1  1 while executing; inputs ignored

Behaviour:
- Reset (RST=1, async): state IDLE; RES, COUT, OFLOW, G, E, L, ERR, RES_VALID, BUSY all 0. Reset mid-operation aborts the operation with no RES_VALID.
- CE=0: no state change, counters hold, outputs hold, RES_VALID forced 0.
- Arithmetic commands (MODE=1):
  - 0 ADD, 1 SUB, 2 ADD_CIN, 3 SUB_CIN, 4 INC_A, 5 DEC_A, 6 INC_B, 7 DEC_B;
  - 8 CMP;
  - 9 MUL_INC = (A+1)*(B+1) mod 2^(2W);
  - 10 MUL_SHL = ((A<<1) mod 2^W)*B.
- Logic commands (MODE=0):
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR;
  - 6 NOT_A, 7 NOT_B;
  - 8 SHR1_A, 9 SHL1_A, 10 SHR1_B, 11 SHL1_B;
  - 12 ROL A by B[log2W-1:0], 13 ROR A by B[log2W-1:0]. For 12/13, any nonzero OPB bit above log2W sets ERR and gives RES=0.
- Any other CMD: ERR=1, RES=0, delivered with normal 1-cycle latency.
- Operand needs: INC_A/DEC_A/NOT_A/SHx_A need A only; INC_B/DEC_B/NOT_B/SHx_B need B only; all others need both.
- FSM states: IDLE, WAIT, EXEC, MUL.
  - IDLE, operands needed all present in INP_VALID: latch CMD, MODE, CIN and operands; go to EXEC, or to MUL for multiply commands.
  - IDLE, partial operands: latch CMD, MODE, CIN and the present operand; go to WAIT with counter=0. INP_VALID=00 stays in IDLE.
  - WAIT: CMD/MODE/CIN changes ignored. Only the missing operand is sampled; if INP_VALID=11, the already-held operand is not overwritten. On arrival go to EXEC or MUL.
  - WAIT: counter increments each CE cycle. If the operand has not arrived when the counter reaches TIMEOUT: ERR=1, RES=0, RES_VALID pulse, back to IDLE.
  - EXEC: outputs registered, RES_VALID=1 for one cycle, then IDLE. Latency is 1 cycle after operand-complete.
  - MUL: counts MUL_LAT-1 cycles, then outputs as in EXEC.
- BUSY=1 in EXEC and MUL. Inputs are ignored while BUSY. A new operation may be accepted in the cycle after RES_VALID.
- Result outputs hold their values between RES_VALID pulses. On each RES_VALID, every flag not produced by the current command is cleared to 0.
- Arithmetic width: ADD/INC give the W+1-bit result, with COUT = bit W. SUB/DEC give the W-bit result, with OFLOW = 1 when the minuend is less than the subtrahend (wrap-around). SUB_CIN subtracts B+CIN.

Test Plan:
- Both operands valid (W=8), MODE=1 CMD=0 A=0xFF B=0x01 INP_VALID=11 → next cycle RES=0x100, COUT=1, RES_VALID pulse, BUSY=0.
- Split operands: A=0x10 with INP_VALID=01, 5 cycles idle, then B=0x20 with INP_VALID=10, CMD=1 (SUB) → RES=0x0F0 (0x10-0x20 mod 256), OFLOW=1, one cycle after B arrives.
- Timeout: INP_VALID=01 only for CMD=0, no B → ERR=1, RES=0, RES_VALID exactly TIMEOUT=16 cycles later; returns to IDLE.
- Multiply: MODE=1 CMD=9 A=0x03 B=0x04 → RES=0x0014 after MUL_LAT=3 cycles. BUSY=1 throughout; a new operation presented while BUSY is ignored.
- Rotate and illegal command: MODE=0 CMD=12 A=0x81 B=0x01 → RES=0x03; with B=0x10 → ERR=1, RES=0. MODE=1 CMD=15 → ERR=1.
- Reset and CE: assert RST mid-MUL → all outputs 0 immediately, no RES_VALID. Hold CE=0 for 4 cycles mid-WAIT → timeout fires 4 cycles later than without the stall.
